// File: rtl/multisim_client_quasi_static_push_mc_if.sv
// Push stream carrying {chan,data} from the change forwarder to its consumer.
interface multisim_client_quasi_static_push_mc_if #(
   parameter int CHAN_W     = 2,
   parameter int DATA_WIDTH = 64
);
   logic                  out_vld;
   logic                  out_rdy;
   logic [CHAN_W-1:0]     out_chan;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (output out_vld, output out_chan, output out_data, input out_rdy);
   modport slave  (input out_vld, input out_chan, input out_data, output out_rdy);
endinterface

// File: rtl/multisim_client_quasi_static_push_mc.sv
// Quasi-static change forwarder: per-channel change FIFOs, newest-entry coalescing on
// overflow, round-robin merge onto a single locked-grant push stream.
module multisim_client_quasi_static_push_mc_fifo #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] head,
   output logic                  empty,
   output logic                  coalesce
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
   logic [PW-1:0] wptr, rptr, tail;
   logic [PW:0]   count;
   logic          full;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign head     = mem[rptr];
   assign tail     = (wptr == '0) ? PW'(DEPTH-1) : wptr - PW'(1);
   // A simultaneous pop frees a slot, so only push-without-pop into full coalesces.
   assign coalesce = push && !pop && full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem   <= '0;
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            if (coalesce) mem[tail] <= wdata;
            else begin
               mem[wptr] <= wdata;
               wptr      <= inc(wptr);
            end
         end
         if (pop) rptr <= inc(rptr);
         if (push && !pop && !full) count <= count + (PW+1)'(1);
         else if (pop && !push)     count <= count - (PW+1)'(1);
      end
   end
endmodule

module multisim_client_quasi_static_push_mc #(
   parameter  int NUM_CHANNELS = 4,
   parameter  int DATA_WIDTH   = 64,
   parameter  int DEPTH        = 4,
   parameter  int CNT_WIDTH    = 16,
   localparam int CHAN_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] data,
   multisim_client_quasi_static_push_mc_if.master bus,
   output logic [CNT_WIDTH-1:0]               ovf_cnt,
   output logic [NUM_CHANNELS-1:0]            ovf_sticky
);
   logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] prev, head;
   logic [NUM_CHANNELS-1:0] push, pop, empty, coal;
   logic                    first, locked, found, xfer;
   logic [CHAN_W-1:0]       rr, gnt_q, gnt, srch;
   logic [CNT_WIDTH:0]      ncoal, ovf_sum;
   int                      idx;

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      assign push[c] = first || (data[c*DATA_WIDTH +: DATA_WIDTH] !== prev[c]);
      assign pop[c]  = xfer && (gnt == CHAN_W'(c));

      multisim_client_quasi_static_push_mc_fifo #(
         .DATA_WIDTH(DATA_WIDTH),
         .DEPTH     (DEPTH)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .push    (push[c]),
         .pop     (pop[c]),
         .wdata   (data[c*DATA_WIDTH +: DATA_WIDTH]),
         .head    (head[c]),
         .empty   (empty[c]),
         .coalesce(coal[c])
      );
   end

   // First non-empty channel at or after the round-robin pointer.
   always_comb begin
      srch  = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         idx = int'(rr) + i;
         if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
         if (!found && !empty[idx]) begin
            found = 1'b1;
            srch  = CHAN_W'(idx);
         end
      end
   end

   assign gnt          = locked ? gnt_q : srch;
   assign bus.out_vld  = locked || found;
   assign bus.out_chan = bus.out_vld ? gnt : '0;
   assign bus.out_data = bus.out_vld ? head[gnt] : '0;
   assign xfer         = bus.out_vld && bus.out_rdy;

   always_comb begin
      ncoal = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) ncoal = ncoal + (CNT_WIDTH+1)'(coal[c]);
      ovf_sum = {1'b0, ovf_cnt} + ncoal;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first      <= 1'b1;
         prev       <= '0;
         rr         <= '0;
         locked     <= 1'b0;
         gnt_q      <= '0;
         ovf_cnt    <= '0;
         ovf_sticky <= '0;
      end else begin
         first <= 1'b0;
         for (int c = 0; c < NUM_CHANNELS; c++)
            if (push[c]) prev[c] <= data[c*DATA_WIDTH +: DATA_WIDTH];
         // A stalled grant is frozen so out_chan/out_data cannot move under backpressure.
         if (xfer) begin
            locked <= 1'b0;
            rr     <= (gnt == CHAN_W'(NUM_CHANNELS-1)) ? '0 : gnt + CHAN_W'(1);
         end else if (bus.out_vld) begin
            locked <= 1'b1;
            gnt_q  <= gnt;
         end
         ovf_cnt    <= ovf_sum[CNT_WIDTH] ? '1 : ovf_sum[CNT_WIDTH-1:0];
         ovf_sticky <= ovf_sticky | coal;
      end
   end
endmodule

// File: tb/tb_multisim_client_quasi_static_push_mc.sv
// Directed bench for the quasi-static change forwarder (4 channels, depth 4).
module tb_multisim_client_quasi_static_push_mc;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [255:0]  data = '0;
   logic [15:0]   ovf_cnt;
   logic [3:0]    ovf_sticky;
   int            tests = 0;
   int            fails = 0;

   multisim_client_quasi_static_push_mc_if #(.CHAN_W(2), .DATA_WIDTH(64)) bus ();

   multisim_client_quasi_static_push_mc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data      (data),
      .bus       (bus),
      .ovf_cnt   (ovf_cnt),
      .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [63:0] v);
      data[c*64 +: 64] = v;
   endtask

   task automatic apply_reset(input logic [63:0] d0, d1, d2, d3, input logic rdy);
      rst_n = 1'b0;
      set_ch(0, d0); set_ch(1, d1); set_ch(2, d2); set_ch(3, d3);
      bus.out_rdy = rdy;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.out_rdy = 1'b1;
      tick(); tick();
      tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL reset_vld: got %0h want 0", bus.out_vld); end
      tests++; if (bus.out_chan !== 2'd0) begin fails++; $display("FAIL reset_chan: got %0h want 0", bus.out_chan); end
      tests++; if (bus.out_data !== 64'd0) begin fails++; $display("FAIL reset_data: got %0h want 0", bus.out_data); end
      tests++; if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL reset_ovf_cnt: got %0h want 0", ovf_cnt); end
      tests++; if (ovf_sticky !== 4'd0) begin fails++; $display("FAIL reset_sticky: got %0h want 0", ovf_sticky); end
   endtask

   task automatic test_power_up();
      apply_reset(64'd1, 64'd2, 64'd3, 64'd4, 1'b1);
      tick();
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (bus.out_vld !== 1'b1 || bus.out_chan !== 2'(k) || bus.out_data !== 64'(k+1)) begin
            fails++;
            $display("FAIL power_up_xfer%0d: got vld=%0h chan=%0h data=%0h want vld=1 chan=%0h data=%0h",
                     k, bus.out_vld, bus.out_chan, bus.out_data, k, k+1);
         end
         tick();
      end
      tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL power_up_idle: got vld=%0h want 0", bus.out_vld); end
   endtask

   task automatic test_stall_and_coalesce();
      logic [1:0]  ec [7];
      logic [63:0] ed [7];
      ec = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2, 2'd2};
      ed = '{64'd1, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd8};
      apply_reset(64'd1, 64'd2, 64'd3, 64'd4, 1'b0);
      tick();
      for (int v = 5; v <= 7; v++) begin
         set_ch(2, 64'(v));
         tick();
         tests++;
         if (bus.out_vld !== 1'b1 || bus.out_chan !== 2'd0 || bus.out_data !== 64'd1) begin
            fails++;
            $display("FAIL stall_stable_v%0d: got vld=%0h chan=%0h data=%0h want vld=1 chan=0 data=1",
                     v, bus.out_vld, bus.out_chan, bus.out_data);
         end
      end
      tests++; if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL fill_no_ovf: got %0h want 0", ovf_cnt); end
      tests++; if (ovf_sticky !== 4'd0) begin fails++; $display("FAIL fill_no_sticky: got %0h want 0", ovf_sticky); end
      set_ch(2, 64'd8);
      tick();
      tests++; if (ovf_cnt !== 16'd1) begin fails++; $display("FAIL coalesce_cnt: got %0h want 1", ovf_cnt); end
      tests++; if (ovf_sticky !== 4'b0100) begin fails++; $display("FAIL coalesce_sticky: got %0h want 4", ovf_sticky); end
      bus.out_rdy = 1'b1;
      for (int k = 0; k < 7; k++) begin
         tests++;
         if (bus.out_vld !== 1'b1 || bus.out_chan !== ec[k] || bus.out_data !== ed[k]) begin
            fails++;
            $display("FAIL coalesce_drain%0d: got vld=%0h chan=%0h data=%0h want vld=1 chan=%0h data=%0h",
                     k, bus.out_vld, bus.out_chan, bus.out_data, ec[k], ed[k]);
         end
         tick();
      end
      tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL coalesce_idle: got vld=%0h want 0", bus.out_vld); end
      tests++; if (ovf_cnt !== 16'd1) begin fails++; $display("FAIL coalesce_cnt_hold: got %0h want 1", ovf_cnt); end
   endtask

   task automatic test_pop_push_full();
      logic [1:0]  ec [5];
      logic [63:0] ed [5];
      ec = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
      ed = '{64'd4, 64'd5, 64'd6, 64'd7, 64'd9};
      apply_reset(64'd1, 64'd2, 64'd3, 64'd4, 1'b0);
      tick();
      for (int v = 5; v <= 7; v++) begin
         set_ch(2, 64'(v));
         tick();
      end
      bus.out_rdy = 1'b1;
      tick(); tick();
      tests++;
      if (bus.out_chan !== 2'd2 || bus.out_data !== 64'd3) begin
         fails++;
         $display("FAIL full_grant: got chan=%0h data=%0h want chan=2 data=3", bus.out_chan, bus.out_data);
      end
      set_ch(2, 64'd9);
      tick();
      bus.out_rdy = 1'b0;
      tests++; if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL full_popush_cnt: got %0h want 0", ovf_cnt); end
      tests++; if (ovf_sticky !== 4'd0) begin fails++; $display("FAIL full_popush_sticky: got %0h want 0", ovf_sticky); end
      bus.out_rdy = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tests++;
         if (bus.out_vld !== 1'b1 || bus.out_chan !== ec[k] || bus.out_data !== ed[k]) begin
            fails++;
            $display("FAIL full_drain%0d: got vld=%0h chan=%0h data=%0h want vld=1 chan=%0h data=%0h",
                     k, bus.out_vld, bus.out_chan, bus.out_data, ec[k], ed[k]);
         end
         tick();
      end
      tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL full_idle: got vld=%0h want 0", bus.out_vld); end
   endtask

   task automatic test_rr_same_edge();
      apply_reset(64'd1, 64'd2, 64'd3, 64'd4, 1'b1);
      for (int k = 0; k < 5; k++) tick();
      set_ch(0, 64'd11);
      tick();
      tests++;
      if (bus.out_vld !== 1'b1 || bus.out_chan !== 2'd0 || bus.out_data !== 64'd11) begin
         fails++;
         $display("FAIL rr_single: got vld=%0h chan=%0h data=%0h want vld=1 chan=0 data=b",
                  bus.out_vld, bus.out_chan, bus.out_data);
      end
      tick();
      set_ch(0, 64'd12);
      set_ch(3, 64'd13);
      tick();
      tests++;
      if (bus.out_vld !== 1'b1 || bus.out_chan !== 2'd3 || bus.out_data !== 64'd13) begin
         fails++;
         $display("FAIL rr_first: got vld=%0h chan=%0h data=%0h want vld=1 chan=3 data=d",
                  bus.out_vld, bus.out_chan, bus.out_data);
      end
      tick();
      tests++;
      if (bus.out_vld !== 1'b1 || bus.out_chan !== 2'd0 || bus.out_data !== 64'd12) begin
         fails++;
         $display("FAIL rr_second: got vld=%0h chan=%0h data=%0h want vld=1 chan=0 data=c",
                  bus.out_vld, bus.out_chan, bus.out_data);
      end
      tick();
      tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL rr_idle: got vld=%0h want 0", bus.out_vld); end
   endtask

   task automatic test_multi_coalesce();
      apply_reset(64'd1, 64'd2, 64'd3, 64'd4, 1'b0);
      tick();
      for (int v = 20; v <= 23; v++) begin
         set_ch(1, 64'(v));
         set_ch(3, 64'(v + 100));
         tick();
      end
      tests++; if (ovf_cnt !== 16'd2) begin fails++; $display("FAIL multi_coal_cnt: got %0h want 2", ovf_cnt); end
      tests++; if (ovf_sticky !== 4'b1010) begin fails++; $display("FAIL multi_coal_sticky: got %0h want a", ovf_sticky); end
   endtask

   task automatic test_reset_mid();
      #2;
      rst_n = 1'b0;
      #1;
      tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL mid_reset_vld: got %0h want 0", bus.out_vld); end
      tests++; if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL mid_reset_cnt: got %0h want 0", ovf_cnt); end
      tests++; if (ovf_sticky !== 4'd0) begin fails++; $display("FAIL mid_reset_sticky: got %0h want 0", ovf_sticky); end
      set_ch(0, 64'd31); set_ch(1, 64'd32); set_ch(2, 64'd33); set_ch(3, 64'd34);
      bus.out_rdy = 1'b1;
      tick();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         tests++;
         if (bus.out_vld !== 1'b1 || bus.out_chan !== 2'(k) || bus.out_data !== 64'(31 + k)) begin
            fails++;
            $display("FAIL mid_reset_xfer%0d: got vld=%0h chan=%0h data=%0h want vld=1 chan=%0h data=%0h",
                     k, bus.out_vld, bus.out_chan, bus.out_data, k, 31 + k);
         end
         tick();
      end
      tests++; if (bus.out_vld !== 1'b0) begin fails++; $display("FAIL mid_reset_idle: got vld=%0h want 0", bus.out_vld); end
   endtask

   initial begin
      bus.out_rdy = 1'b0;
      test_reset();
      test_power_up();
      test_stall_and_coalesce();
      test_pop_push_full();
      test_rr_same_edge();
      test_multi_coalesce();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
